// File: rtl/usadd_s2b_window.sv
`default_nettype none
// ============================================================================
// Module      : usadd_s2b_window
// Description : Stochastic-to-binary converter for the unipolar scaled adder.
//               Counts ones over a window of 2^BITWIDTH valid samples, scales
//               the count by the adder input count and offers the result on a
//               valid/ready handshake. Pulses a clear upstream at each window
//               start so the adder's Sobol sequence lines up with the window.
// Revision    : 1.0 - initial release
// ============================================================================
module usadd_s2b_window #(
    parameter int BITWIDTH    = 8,
    parameter int SCALE_SHIFT = 1
) (
    input  logic                            iClk,
    input  logic                            iRst,
    input  logic                            iBit,
    input  logic                            iBitVld,
    input  logic                            iStart,
    input  logic                            iCont,
    input  logic                            iAbort,
    input  logic                            iRdy,
    output logic                            oClr,
    output logic                            oBusy,
    output logic                            oVld,
    output logic [BITWIDTH:0]               oCnt,
    output logic [BITWIDTH+SCALE_SHIFT:0]   oSum
);

    localparam int CW = BITWIDTH + 1;
    localparam int SW = BITWIDTH + SCALE_SHIFT + 1;
    // Sample count just before the window-closing sample is taken.
    localparam logic [CW-1:0] C_LAST = CW'((1 << BITWIDTH) - 1);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_ACC  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t          r_state;
    logic [CW-1:0]   r_sampCnt;
    logic [CW-1:0]   r_oneCnt;
    logic [CW-1:0]   w_oneNext;
    logic [SW-1:0]   w_sumNext;

    // Ones count including the current sample, and its scaled form.
    assign w_oneNext = r_oneCnt + {{BITWIDTH{1'b0}}, iBit};
    assign w_sumNext = SW'(w_oneNext) << SCALE_SHIFT;

    // Window FSM: accumulation, result capture, handshake and upstream clear.
    always_ff @(posedge iClk or posedge iRst) begin
        if (iRst) begin
            r_state   <= S_IDLE;
            r_sampCnt <= '0;
            r_oneCnt  <= '0;
            oClr      <= 1'b0;
            oBusy     <= 1'b0;
            oVld      <= 1'b0;
            oCnt      <= '0;
            oSum      <= '0;
        end else if (iAbort) begin
            // Abort wins over everything but reset; the last result is kept.
            r_state   <= S_IDLE;
            r_sampCnt <= '0;
            r_oneCnt  <= '0;
            oClr      <= 1'b0;
            oBusy     <= 1'b0;
            oVld      <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    oClr <= 1'b0;
                    if (iStart) begin
                        r_state   <= S_ACC;
                        r_sampCnt <= '0;
                        r_oneCnt  <= '0;
                        oClr      <= 1'b1;
                        oBusy     <= 1'b1;
                    end
                end

                S_ACC: begin
                    oClr <= 1'b0;
                    // While oClr is high the upstream RNG is still stale, so
                    // samples in that cycle are dropped.
                    if (!oClr && iBitVld) begin
                        r_sampCnt <= r_sampCnt + CW'(1);
                        r_oneCnt  <= w_oneNext;
                        if (r_sampCnt == C_LAST) begin
                            r_state <= S_DONE;
                            oVld    <= 1'b1;
                            oCnt    <= w_oneNext;
                            oSum    <= w_sumNext;
                        end
                    end
                end

                S_DONE: begin
                    oClr <= 1'b0;
                    if (oVld && iRdy) begin
                        oVld      <= 1'b0;
                        r_sampCnt <= '0;
                        r_oneCnt  <= '0;
                        if (iCont) begin
                            r_state <= S_ACC;
                            oClr    <= 1'b1;
                        end else begin
                            r_state <= S_IDLE;
                            oBusy   <= 1'b0;
                        end
                    end
                end

                default: begin
                    r_state <= S_IDLE;
                    oClr    <= 1'b0;
                    oBusy   <= 1'b0;
                    oVld    <= 1'b0;
                end
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_usadd_s2b_window.sv
`default_nettype none
// ============================================================================
// Module      : tb_usadd_s2b_window
// Description : Self-checking bench for usadd_s2b_window (BITWIDTH=4,
//               SCALE_SHIFT=1) with an expected-result scoreboard queue.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_usadd_s2b_window;

    localparam int BITWIDTH    = 4;
    localparam int SCALE_SHIFT = 1;
    localparam int WIN         = 1 << BITWIDTH;

    logic                          iClk;
    logic                          iRst;
    logic                          iBit;
    logic                          iBitVld;
    logic                          iStart;
    logic                          iCont;
    logic                          iAbort;
    logic                          iRdy;
    logic                          oClr;
    logic                          oBusy;
    logic                          oVld;
    logic [BITWIDTH:0]             oCnt;
    logic [BITWIDTH+SCALE_SHIFT:0] oSum;

    int nCmp;
    int nErr;
    int expQ[$];

    usadd_s2b_window #(
        .BITWIDTH    (BITWIDTH),
        .SCALE_SHIFT (SCALE_SHIFT)
    ) dut (
        .iClk    (iClk),
        .iRst    (iRst),
        .iBit    (iBit),
        .iBitVld (iBitVld),
        .iStart  (iStart),
        .iCont   (iCont),
        .iAbort  (iAbort),
        .iRdy    (iRdy),
        .oClr    (oClr),
        .oBusy   (oBusy),
        .oVld    (oVld),
        .oCnt    (oCnt),
        .oSum    (oSum)
    );

    initial begin
        iClk = 1'b0;
        forever #5 iClk = ~iClk;
    end

    // Single comparison point for the whole bench.
    task automatic checkVal(input string tag, input logic [31:0] act, input logic [31:0] exp);
        nCmp++;
        if (act !== exp) begin
            nErr++;
            $display("FAIL %s: got %0d, expected %0d", tag, act, exp);
        end
    endtask

    // Pops the next expected count and compares it with the presented result.
    task automatic checkResult(input string tag);
        int e;
        checkVal({tag, "_vld"}, 32'(oVld), 32'd1);
        if (expQ.size() == 0) begin
            nCmp++;
            nErr++;
            $display("FAIL %s_queue: got result %0d, expected none queued", tag, oCnt);
        end else begin
            e = expQ.pop_front();
            checkVal({tag, "_cnt"}, 32'(oCnt), 32'(e));
            checkVal({tag, "_sum"}, 32'(oSum), 32'(e * (1 << SCALE_SHIFT)));
        end
    endtask

    // Entered on the negedge where oClr is visible. Drives a poison sample in
    // the clear cycle, then WIN valid samples (pat 0: zeros, 1: ones,
    // 2: alternating 1,0), optionally gapping every third cycle. Returns on
    // the negedge right after the last sample edge.
    task automatic feedWindow(input int pat, input bit gap);
        int n;
        int ones;
        int cyc;
        logic b;
        n    = 0;
        ones = 0;
        cyc  = 0;
        iRdy = 1'b0;
        iBitVld = 1'b1;
        iBit    = 1'b1;
        @(negedge iClk);
        while (n < WIN) begin
            if (gap && (cyc % 3 == 2)) begin
                iBitVld = 1'b0;
                iBit    = 1'b1;
            end else begin
                b = (pat == 1) ? 1'b1 : (pat == 2) ? ((n % 2) == 0) : 1'b0;
                iBitVld = 1'b1;
                iBit    = b;
                ones   += int'(b);
                n++;
            end
            cyc++;
            @(negedge iClk);
        end
        iBitVld = 1'b0;
        iBit    = 1'b0;
        expQ.push_back(ones);
    endtask

    initial begin
        nCmp    = 0;
        nErr    = 0;
        iRst    = 1'b1;
        iBit    = 1'b0;
        iBitVld = 1'b0;
        iStart  = 1'b0;
        iCont   = 1'b0;
        iAbort  = 1'b0;
        iRdy    = 1'b0;

        // Reset state
        @(negedge iClk);
        @(negedge iClk);
        checkVal("rst_clr", 32'(oClr), 0);
        checkVal("rst_busy", 32'(oBusy), 0);
        checkVal("rst_vld", 32'(oVld), 0);
        checkVal("rst_cnt", 32'(oCnt), 0);
        checkVal("rst_sum", 32'(oSum), 0);
        iRst = 1'b0;
        @(negedge iClk);

        // All-ones window, then a held result
        iStart = 1'b1;
        @(negedge iClk);
        iStart = 1'b0;
        checkVal("t1_clr", 32'(oClr), 1);
        checkVal("t1_busy", 32'(oBusy), 1);
        feedWindow(1, 1'b0);
        checkResult("t1");
        for (int i = 0; i < 5; i++) begin
            iBitVld = 1'b1;
            iBit    = i[0];
            @(negedge iClk);
            checkVal("hold_vld", 32'(oVld), 1);
            checkVal("hold_cnt", 32'(oCnt), 16);
        end
        iBitVld = 1'b0;
        iRdy    = 1'b1;
        iCont   = 1'b0;
        @(negedge iClk);
        iRdy = 1'b0;
        checkVal("hs_vld", 32'(oVld), 0);
        checkVal("hs_busy", 32'(oBusy), 0);
        checkVal("hs_keepcnt", 32'(oCnt), 16);

        // Alternating pattern with gaps, then two continuous windows
        iStart = 1'b1;
        @(negedge iClk);
        iStart = 1'b0;
        checkVal("t2_clr", 32'(oClr), 1);
        feedWindow(2, 1'b1);
        checkResult("t2");
        iRdy  = 1'b1;
        iCont = 1'b1;
        @(negedge iClk);
        checkVal("c1_clr", 32'(oClr), 1);
        checkVal("c1_vld", 32'(oVld), 0);
        feedWindow(1, 1'b0);
        checkResult("c1");
        iRdy  = 1'b1;
        iCont = 1'b1;
        @(negedge iClk);
        checkVal("c2_clr", 32'(oClr), 1);
        feedWindow(0, 1'b0);
        checkResult("c2");
        iRdy  = 1'b1;
        iCont = 1'b0;
        @(negedge iClk);
        iRdy = 1'b0;
        checkVal("c2_idle", 32'(oBusy), 0);

        // Abort after 7 samples, then start+abort together, then a fresh window
        iStart = 1'b1;
        @(negedge iClk);
        iStart = 1'b0;
        checkVal("ab_clr", 32'(oClr), 1);
        for (int i = 0; i < 8; i++) begin
            iBitVld = 1'b1;
            iBit    = 1'b1;
            @(negedge iClk);
        end
        iBitVld = 1'b0;
        iAbort  = 1'b1;
        @(negedge iClk);
        checkVal("ab_busy", 32'(oBusy), 0);
        checkVal("ab_vld", 32'(oVld), 0);
        checkVal("ab_clr0", 32'(oClr), 0);
        iStart = 1'b1;
        @(negedge iClk);
        checkVal("ab_startabort", 32'(oBusy), 0);
        iAbort = 1'b0;
        @(negedge iClk);
        iStart = 1'b0;
        checkVal("ab2_clr", 32'(oClr), 1);
        feedWindow(2, 1'b0);
        checkResult("ab2");
        iRdy  = 1'b1;
        iCont = 1'b0;
        @(negedge iClk);
        iRdy = 1'b0;

        // Asynchronous reset mid-window
        iStart = 1'b1;
        @(negedge iClk);
        iStart = 1'b0;
        for (int i = 0; i < 6; i++) begin
            iBitVld = 1'b1;
            iBit    = 1'b1;
            @(negedge iClk);
        end
        @(posedge iClk);
        #2;
        iRst = 1'b1;
        #1;
        checkVal("ar_clr", 32'(oClr), 0);
        checkVal("ar_busy", 32'(oBusy), 0);
        checkVal("ar_vld", 32'(oVld), 0);
        checkVal("ar_cnt", 32'(oCnt), 0);
        checkVal("ar_sum", 32'(oSum), 0);
        @(negedge iClk);
        iRst    = 1'b0;
        iBitVld = 1'b0;
        iStart  = 1'b1;
        @(negedge iClk);
        iStart = 1'b0;
        checkVal("ar_restart_clr", 32'(oClr), 1);
        checkVal("ar_restart_busy", 32'(oBusy), 1);
        feedWindow(1, 1'b0);
        checkResult("ar2");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCmp, nErr);
        $finish;
    end

    // Run-time bound so the bench can never hang.
    initial begin
        #200000;
        $display("FAIL timeout: got no completion, expected finish before 200000");
        $fatal(1, "timeout");
    end

endmodule
`default_nettype wire
